frame_buffer_arbiter: RTL and testbench

// Owns the single-port-write / single-port-read frame RAM and shares it between the VGA scanout
// (read, every pixel clock) and the drawing engine (pixel writes) plus a full-screen clear.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/pixel_write_fifo.sv | 50 +++++
 rtl/frame_buffer_arbiter.sv | 109 ++++++++++
 tb/tb_frame_buffer_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, FSM states and the queued-write record for the frame buffer arbiter.
package fb_pkg;
    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int PIX_W      = 5;
    localparam int ADDR_W     = 19;
    localparam int FIFO_DEPTH = 16;
    localparam logic [PIX_W-1:0] KEY_PIX   = 5'h15;
    localparam logic [PIX_W-1:0] CLEAR_PIX = 5'h01;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} fb_arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  pix;
    } fb_wr_t;

    function automatic logic [ADDR_W-1:0] pixAddr(input logic [9:0] x, input logic [9:0] y, input int hRes);
        return ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(hRes);
    endfunction
endpackage

// File: rtl/pixel_write_fifo.sv
// pixel_write_fifo: synchronous queue of pending pixel writes with registered full/empty flags.
module pixel_write_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   Clk,
    input  logic   Reset,
    input  logic   push,
    input  logic   pop,
    input  fb_wr_t pushData,
    output fb_wr_t popData,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fb_wr_t mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count, countNext;
    logic doPush, doPop;

    // A push while full is refused even if a pop happens in the same cycle.
    assign doPush = push && !full;
    assign doPop = pop && !empty;
    assign popData = mem[rdPtr];
    assign countNext = count + (AW+1)'(doPush) - (AW+1)'(doPop);

    always_ff @(posedge Clk) begin
        if (doPush)
            mem[wrPtr] <= pushData;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            wrPtr <= doPush ? wrPtr + 1'b1 : wrPtr;
            rdPtr <= doPop ? rdPtr + 1'b1 : rdPtr;
            count <= countNext;
            full <= countNext == FULL_CNT;
            empty <= countNext == '0;
        end
    end
endmodule

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares the frame RAM between scanout reads and queued draw writes / clears,
// committing writes only during blanking.
module frame_buffer_arbiter #(
    parameter int H_RES      = fb_pkg::H_RES,
    parameter int V_RES      = fb_pkg::V_RES,
    parameter int FIFO_DEPTH = fb_pkg::FIFO_DEPTH
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      blank,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [9:0]                wr_x,
    input  logic [9:0]                wr_y,
    input  logic [fb_pkg::PIX_W-1:0]  wr_pix,
    input  logic                      clear_req,
    output logic                      clear_busy,
    output logic                      ram_we,
    output logic [fb_pkg::ADDR_W-1:0] ram_waddr,
    output logic [fb_pkg::PIX_W-1:0]  ram_wdata,
    output logic [fb_pkg::ADDR_W-1:0] ram_raddr,
    input  logic [fb_pkg::PIX_W-1:0]  ram_rdata,
    output logic [fb_pkg::PIX_W-1:0]  pixel_out
);
    import fb_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    fb_arb_state_e state, stateNext;
    fb_wr_t wrEntry, headEntry;
    logic fifoFull, fifoEmpty, push, pop, inRange;
    logic weNext, clearBusyNext;
    logic [ADDR_W-1:0] waddrNext, clrCnt, clrCntNext;
    logic [PIX_W-1:0] wdataNext;

    assign ram_raddr = pixAddr(DrawX, DrawY, H_RES);
    assign pixel_out = ram_rdata;
    assign wr_ready = !fifoFull;

    // Transparent or off-screen requests complete the handshake but never reach the queue.
    assign inRange = (32'(wr_x) < H_RES) && (32'(wr_y) < V_RES);
    assign push = wr_valid && wr_ready && inRange && (wr_pix != KEY_PIX);
    assign wrEntry = '{addr: pixAddr(wr_x, wr_y, H_RES), pix: wr_pix};

    pixel_write_fifo #(.DEPTH(FIFO_DEPTH)) writeQueue (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (push),
        .pop      (pop),
        .pushData (wrEntry),
        .popData  (headEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_comb begin
        stateNext = state;
        pop = 1'b0;
        weNext = 1'b0;
        waddrNext = ram_waddr;
        wdataNext = ram_wdata;
        clrCntNext = clrCnt;
        clearBusyNext = clear_busy || clear_req;
        case (state)
            IDLE:
                stateNext = (clear_busy && blank) ? CLEAR : (!fifoEmpty && blank) ? DRAIN : IDLE;
            DRAIN:
                if (fifoEmpty || !blank || clear_busy) begin
                    stateNext = IDLE;
                end else begin
                    pop = 1'b1;
                    weNext = 1'b1;
                    waddrNext = headEntry.addr;
                    wdataNext = headEntry.pix;
                end
            CLEAR:
                if (blank) begin
                    weNext = 1'b1;
                    waddrNext = clrCnt;
                    wdataNext = CLEAR_PIX;
                    clrCntNext = (clrCnt == LAST_ADDR) ? '0 : clrCnt + 1'b1;
                    clearBusyNext = clrCnt != LAST_ADDR;
                    stateNext = (clrCnt == LAST_ADDR) ? IDLE : CLEAR;
                end
            default:
                stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            ram_we <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            clrCnt <= '0;
            clear_busy <= 1'b0;
        end else begin
            state <= stateNext;
            ram_we <= weNext;
            ram_waddr <= waddrNext;
            ram_wdata <= wdataNext;
            clrCnt <= clrCntNext;
            clear_busy <= clearBusyNext;
        end
    end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: scoreboard bench for frame_buffer_arbiter on a 640x32 frame.
module tb_frame_buffer_arbiter;
    localparam int H = 640;
    localparam int V = 32;
    localparam int NPIX = H * V;

    logic Clk = 0, Reset = 1, blank = 0, wr_valid = 0, clear_req = 0;
    logic [9:0] DrawX = 0, DrawY = 0, wr_x = 0, wr_y = 0;
    logic [4:0] wr_pix = 0, ram_rdata = 0;
    logic wr_ready, clear_busy, ram_we;
    logic [18:0] ram_waddr, ram_raddr;
    logic [4:0] ram_wdata, pixel_out;

    typedef struct { int addr; int pix; } exp_t;
    exp_t expQ[$];
    exp_t monE;
    int checks = 0, errors = 0, wrCount = 0, clrNext = 0, clrLeft = 0;
    logic prevBlank = 0, clrStarted = 0;

    always #5 Clk = ~Clk;

    frame_buffer_arbiter #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .blank(blank), .DrawX(DrawX), .DrawY(DrawY),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_pix(wr_pix),
        .clear_req(clear_req), .clear_busy(clear_busy), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .pixel_out(pixel_out)
    );

    // Every RAM write is matched against the clear sequence or the queue of expected draws.
    always @(negedge Clk) begin
        if (ram_we) begin
            wrCount++;
            checks++;
            if (!prevBlank) begin errors++; $display("FAIL blank_guard: write addr %0d decided with blank=0", ram_waddr); end
            checks++;
            if (clrLeft > 0 && ram_wdata == 5'h01) begin
                if (int'(ram_waddr) !== clrNext) begin errors++; $display("FAIL clear_addr: got %0d expected %0d", ram_waddr, clrNext); end
                clrNext++;
                clrLeft--;
                clrStarted = clrLeft != 0;
            end else if (clrStarted) begin
                errors++; $display("FAIL draw_during_clear: addr %0d data %0h written while clear in progress", ram_waddr, ram_wdata);
            end else if (expQ.size() == 0) begin
                errors++; $display("FAIL unexpected_write: addr %0d data %0h, nothing expected", ram_waddr, ram_wdata);
            end else begin
                monE = expQ.pop_front();
                if (ram_waddr !== 19'(monE.addr) || ram_wdata !== 5'(monE.pix)) begin
                    errors++; $display("FAIL draw_write: got addr %0d data %0h expected addr %0d data %0h", ram_waddr, ram_wdata, monE.addr, monE.pix);
                end
            end
        end
        prevBlank = blank;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic drive_wr(input int x, input int y, input int pix, output logic acc);
        wr_valid = 1; wr_x = 10'(x); wr_y = 10'(y); wr_pix = 5'(pix);
        acc = wr_ready;
        tick();
        wr_valid = 0;
        if (acc && x < H && y < V && pix != 'h15) expQ.push_back('{x + y * H, pix});
    endtask

    task automatic start_clear();
        clear_req = 1; clrNext = 0; clrLeft = NPIX;
        tick();
        clear_req = 0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while ((expQ.size() != 0 || clrLeft != 0) && n < limit) begin tick(); n++; end
        checks++;
        if (expQ.size() != 0 || clrLeft != 0) begin
            errors++; $display("FAIL %s_timeout: %0d draws and %0d clears still pending", name, expQ.size(), clrLeft);
        end
    endtask

    task automatic test_reset();
        Reset = 1; tick(3);
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", ram_we); end
        checks++; if (ram_waddr !== 19'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", ram_waddr); end
        checks++; if (ram_wdata !== 5'd0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", ram_wdata); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy: got %b expected 0", clear_busy); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (pixel_out !== 5'd0) begin errors++; $display("FAIL reset_pixel_out: got %0h expected 0", pixel_out); end
        Reset = 0; tick();
    endtask

    task automatic test_read_path();
        int xs[4] = '{0, 639, 10, 5};
        int ys[4] = '{0, 31, 2, 479};
        logic [4:0] rd;
        for (int i = 0; i < 4; i++) begin
            DrawX = 10'(xs[i]); DrawY = 10'(ys[i]); rd = 5'($urandom); ram_rdata = rd;
            #1;
            checks++; if (ram_raddr !== 19'(xs[i] + ys[i] * H)) begin errors++; $display("FAIL read_addr: got %0d expected %0d", ram_raddr, xs[i] + ys[i] * H); end
            checks++; if (pixel_out !== rd) begin errors++; $display("FAIL pixel_out: got %0h expected %0h", pixel_out, rd); end
        end
        ram_rdata = 0;
    endtask

    task automatic test_single();
        int base;
        logic acc;
        blank = 0;
        drive_wr(10, 2, 3, acc);
        base = wrCount;
        tick(10);
        checks++; if (wrCount !== base) begin errors++; $display("FAIL single_held: got %0d writes expected 0", wrCount - base); end
        blank = 1;
        wait_drain("single", 20);
        tick(5);
        checks++; if (wrCount - base !== 1) begin errors++; $display("FAIL single_count: got %0d writes expected 1", wrCount - base); end
    endtask

    task automatic test_fill();
        int base, c1 = -1, c16 = -1;
        logic acc;
        blank = 0;
        for (int i = 0; i < 17; i++) begin
            drive_wr(i, 1, i + 2, acc);
            checks++; if (acc !== (i < 16)) begin errors++; $display("FAIL fill_ready[%0d]: got %b expected %b", i, acc, i < 16); end
        end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill_full: wr_ready got %b expected 0", wr_ready); end
        base = wrCount;
        blank = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (wrCount - base == 1 && c1 < 0) c1 = c;
            if (wrCount - base == 16 && c16 < 0) c16 = c;
        end
        checks++; if (c1 < 0 || c16 - c1 !== 15) begin errors++; $display("FAIL fill_burst: first write cycle %0d, 16th cycle %0d, expected 15 apart", c1, c16); end
        checks++; if (wrCount - base !== 16) begin errors++; $display("FAIL fill_count: got %0d writes expected 16", wrCount - base); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after: got %b expected 1", wr_ready); end
        wait_drain("fill", 10);
    endtask

    task automatic test_discard();
        int base;
        logic acc;
        blank = 1;
        base = wrCount;
        drive_wr(0, 0, 'h15, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL discard_key_acc: got %b expected 1", acc); end
        drive_wr(640, 0, 7, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL discard_x_acc: got %b expected 1", acc); end
        drive_wr(0, V, 7, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL discard_y_acc: got %b expected 1", acc); end
        tick(10);
        checks++; if (wrCount !== base) begin errors++; $display("FAIL discard_writes: got %0d writes expected 0", wrCount - base); end
    endtask

    task automatic test_back_to_back();
        int base;
        logic acc;
        blank = 1;
        base = wrCount;
        for (int i = 0; i < 8; i++) begin
            drive_wr(200 + i, 5, i + 2, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_acc[%0d]: got %b expected 1", i, acc); end
        end
        wait_drain("b2b", 20);
        checks++; if (wrCount - base !== 8) begin errors++; $display("FAIL b2b_count: got %0d writes expected 8", wrCount - base); end
    endtask

    task automatic test_clear();
        int base, cyc = 0;
        logic early = 0;
        base = wrCount;
        blank = 1;
        start_clear();
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_set: got %b expected 1", clear_busy); end
        while ((clrLeft != 0 || clear_busy) && cyc < 40000) begin
            blank = (cyc % 150) < 100;
            clear_req = cyc == 5000;
            if (clear_busy !== 1'b1 && clrLeft > 1) early = 1;
            tick();
            cyc++;
        end
        clear_req = 0;
        blank = 1;
        tick(2);
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL clear_busy_early: dropped with %0d clears pending", clrLeft); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL clear_busy_end: got %b expected 0", clear_busy); end
        checks++; if (clrLeft !== 0) begin errors++; $display("FAIL clear_timeout: %0d clears pending", clrLeft); end
        checks++; if (wrCount - base !== NPIX) begin errors++; $display("FAIL clear_count: got %0d writes expected %0d", wrCount - base, NPIX); end
    endtask

    task automatic test_preempt();
        int base, n = 0;
        logic acc;
        blank = 0;
        base = wrCount;
        for (int i = 0; i < 4; i++) drive_wr(100 + i, 3, i + 2, acc);
        blank = 1;
        while (wrCount == base && n < 20) begin tick(); n++; end
        checks++; if (wrCount == base) begin errors++; $display("FAIL preempt_start: got 0 writes expected drain to begin"); end
        start_clear();
        tick(4);
        checks++; if (expQ.size() < 1) begin errors++; $display("FAIL preempt_pending: got %0d queued draws expected at least 1", expQ.size()); end
        wait_drain("preempt", NPIX + 200);
        tick(3);
        checks++; if (wrCount - base !== NPIX + 4) begin errors++; $display("FAIL preempt_count: got %0d writes expected %0d", wrCount - base, NPIX + 4); end
    endtask

    task automatic test_reset_mid();
        int base;
        logic acc;
        blank = 0;
        for (int i = 0; i < 3; i++) drive_wr(300 + i, 4, i + 2, acc);
        start_clear();
        blank = 1;
        tick(50);
        checks++; if (clrNext == 0) begin errors++; $display("FAIL reset_mid_clear: got 0 clear writes expected clear running"); end
        Reset = 1;
        tick();
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_mid_we: got %b expected 0", ram_we); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", clear_busy); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b expected 1", wr_ready); end
        expQ.delete();
        clrLeft = 0;
        clrStarted = 0;
        Reset = 0;
        base = wrCount;
        tick(40);
        checks++; if (wrCount !== base) begin errors++; $display("FAIL reset_mid_quiet: got %0d writes expected 0", wrCount - base); end
        drive_wr(1, 1, 9, acc);
        wait_drain("reset_mid", 20);
        tick(3);
        checks++; if (wrCount - base !== 1) begin errors++; $display("FAIL reset_mid_resume: got %0d writes expected 1", wrCount - base); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_path();
        test_single();
        test_fill();
        test_discard();
        test_back_to_back();
        test_clear();
        test_preempt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
